// File: rtl/i2c_master_byte_sequencer.sv
// i2c_master_byte_sequencer
// Byte-level I2C master sequencer. It turns one host request (start / write / read /
// stop plus the ACK bit to send) into the bit-controller command stream:
// START, eight data bits MSB first, the ACK slot, then STOP.
// It shifts the tx/rx byte, reports the ACK seen in the ACK slot and pulses
// o_cmd_ack for one cycle when the request completes. Arbitration loss aborts
// the request and returns to idle without issuing STOP.
module i2c_master_byte_sequencer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_read,
  input  logic       i_write,
  input  logic       i_ack_in,
  input  logic [7:0] i_din,
  output logic       o_cmd_ack,
  output logic       o_ack_out,
  output logic [7:0] o_dout,
  output logic       o_i2c_al,
  output logic [3:0] o_core_cmd,
  output logic       o_core_txd,
  input  logic       i_core_ack,
  input  logic       i_core_rxd,
  input  logic       i_core_al
);

  // Bit-controller command codes
  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t     r_state;
  logic [7:0] r_sr;
  logic [2:0] r_cnt;
  logic [3:0] r_core_cmd;
  logic       r_core_txd;
  logic       r_cmd_ack;
  logic       r_ack_out;
  logic       r_i2c_al;
  logic       w_go;

  // A new request is accepted only outside the done-pulse cycle, so a host that
  // still holds its request lines while cmd_ack is high does not retrigger.
  assign w_go = (i_start | i_stop | i_read | i_write) & ~r_cmd_ack;

  // Sequencer FSM: issues bit commands, shifts the byte, generates the done pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_sr       <= 8'h00;
      r_cnt      <= 3'd0;
      r_core_cmd <= CMD_NOP;
      r_core_txd <= 1'b0;
      r_cmd_ack  <= 1'b0;
      r_ack_out  <= 1'b0;
      r_i2c_al   <= 1'b0;
    end else begin
      r_cmd_ack <= 1'b0;
      r_i2c_al  <= i_core_al;
      if (i_core_al) begin
        // Lost arbitration: drop everything, keep shifted data and last ACK
        r_state    <= ST_IDLE;
        r_core_cmd <= CMD_NOP;
        r_core_txd <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_go) begin
              r_sr  <= i_din;
              r_cnt <= 3'd7;
              if (i_start) begin
                r_state    <= ST_START;
                r_core_cmd <= CMD_START;
              end else if (i_read) begin
                r_state    <= ST_READ;
                r_core_cmd <= CMD_READ;
              end else if (i_write) begin
                r_state    <= ST_WRITE;
                r_core_cmd <= CMD_WRITE;
                r_core_txd <= i_din[7];
              end else begin
                r_state    <= ST_STOP;
                r_core_cmd <= CMD_STOP;
              end
            end
          end
          ST_START: begin
            if (i_core_ack) begin
              if (i_read) begin
                r_state    <= ST_READ;
                r_core_cmd <= CMD_READ;
              end else if (i_write) begin
                r_state    <= ST_WRITE;
                r_core_cmd <= CMD_WRITE;
                r_core_txd <= r_sr[7];
              end else begin
                r_state    <= ST_IDLE;
                r_core_cmd <= CMD_NOP;
                r_cmd_ack  <= 1'b1;
              end
            end
          end
          ST_WRITE, ST_READ: begin
            if (i_core_ack) begin
              r_sr <= {r_sr[6:0], i_core_rxd};
              if (r_cnt != 3'd0) begin
                // Next data bit follows immediately with the same command
                r_cnt <= r_cnt - 3'd1;
                if (r_state == ST_WRITE) begin
                  r_core_txd <= r_sr[6];
                end
              end else begin
                r_state <= ST_ACK;
                if (r_state == ST_WRITE) begin
                  // Release SDA and read the slave ACK
                  r_core_cmd <= CMD_READ;
                  r_core_txd <= 1'b1;
                end else begin
                  // Drive the master ACK/NACK chosen by the host
                  r_core_cmd <= CMD_WRITE;
                  r_core_txd <= i_ack_in;
                end
              end
            end
          end
          ST_ACK: begin
            if (i_core_ack) begin
              r_ack_out <= i_core_rxd;
              if (i_stop) begin
                r_state    <= ST_STOP;
                r_core_cmd <= CMD_STOP;
              end else begin
                r_state    <= ST_IDLE;
                r_core_cmd <= CMD_NOP;
                r_cmd_ack  <= 1'b1;
              end
            end
          end
          ST_STOP: begin
            if (i_core_ack) begin
              r_state    <= ST_IDLE;
              r_core_cmd <= CMD_NOP;
              r_cmd_ack  <= 1'b1;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_core_cmd <= CMD_NOP;
            r_core_txd <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_cmd_ack  = r_cmd_ack;
  assign o_ack_out  = r_ack_out;
  assign o_dout     = r_sr;
  assign o_i2c_al   = r_i2c_al;
  assign o_core_cmd = r_core_cmd;
  assign o_core_txd = r_core_txd;

endmodule

// File: tb/tb_i2c_master_byte_sequencer.sv
// Self-checking bench for i2c_master_byte_sequencer. A behavioural bit-controller
// answers each command after a random delay; the expected command stream, byte
// and ACK result of every request are derived from the request itself.
module tb_i2c_master_byte_sequencer;

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  localparam logic [1:0] K_CTRL = 2'd0;
  localparam logic [1:0] K_DATA = 2'd1;
  localparam logic [1:0] K_ACK  = 2'd2;

  typedef struct {
    logic [3:0] cmd;
    logic       txd;
    logic       care;
    logic       rx;
    logic [1:0] kind;
  } step_t;

  logic       i_clk, i_rst;
  logic       i_start, i_stop, i_read, i_write, i_ack_in;
  logic [7:0] i_din;
  logic       o_cmd_ack, o_ack_out, o_i2c_al, o_core_txd;
  logic [7:0] o_dout;
  logic [3:0] o_core_cmd;
  logic       i_core_ack, i_core_rxd, i_core_al;

  int   n_checks = 0;
  int   n_errs   = 0;
  logic [7:0] m_sr;
  logic       m_ack_out;

  i2c_master_byte_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_start(i_start), .i_stop(i_stop), .i_read(i_read), .i_write(i_write),
    .i_ack_in(i_ack_in), .i_din(i_din),
    .o_cmd_ack(o_cmd_ack), .o_ack_out(o_ack_out), .o_dout(o_dout), .o_i2c_al(o_i2c_al),
    .o_core_cmd(o_core_cmd), .o_core_txd(o_core_txd),
    .i_core_ack(i_core_ack), .i_core_rxd(i_core_rxd), .i_core_al(i_core_al)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic [3:0] cmd, input logic txd, input logic care,
                               input logic rx, input logic [1:0] kind);
    step_t st;
    st.cmd = cmd; st.txd = txd; st.care = care; st.rx = rx; st.kind = kind;
    return st;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd"},    32'(o_core_cmd), 32'(CMD_NOP));
    check({tag, "_txd"},    32'(o_core_txd), 32'd0);
    check({tag, "_cmdack"}, 32'(o_cmd_ack),  32'd0);
    check({tag, "_ackout"}, 32'(o_ack_out),  32'd0);
    check({tag, "_dout"},   32'(o_dout),     32'h00);
    check({tag, "_al"},     32'(o_i2c_al),   32'd0);
  endtask

  task automatic drop_host();
    i_start = 1'b0; i_stop = 1'b0; i_read = 1'b0; i_write = 1'b0; i_ack_in = 1'b0;
  endtask

  // abort_kind: 0 none, 1 arbitration loss at step abort_idx, 2 reset at step abort_idx
  task automatic do_req(input logic s, input logic p, input logic r, input logic w,
                        input logic ak, input logic [7:0] din, input logic [7:0] rxb,
                        input logic rxa, input int maxdly, input int abort_kind,
                        input int abort_idx);
    step_t q[$];
    int bi = 0;
    int cyc = 0;
    int d;
    bit done = 1'b0;
    logic [3:0] c;
    logic t;
    // Expected bit-command stream of this request
    if (r || w) begin
      if (s) q.push_back(mk(CMD_START, 1'b0, 1'b0, 1'($urandom), K_CTRL));
      if (r) begin
        for (int i = 0; i < 8; i++) q.push_back(mk(CMD_READ, 1'b0, 1'b0, rxb[7-i], K_DATA));
        q.push_back(mk(CMD_WRITE, ak, 1'b1, ak, K_ACK));
      end else begin
        for (int i = 0; i < 8; i++) q.push_back(mk(CMD_WRITE, din[7-i], 1'b1, din[7-i], K_DATA));
        q.push_back(mk(CMD_READ, 1'b1, 1'b1, rxa, K_ACK));
      end
      if (p) q.push_back(mk(CMD_STOP, 1'b0, 1'b0, 1'($urandom), K_CTRL));
    end else if (s) begin
      q.push_back(mk(CMD_START, 1'b0, 1'b0, 1'($urandom), K_CTRL));
    end else begin
      q.push_back(mk(CMD_STOP, 1'b0, 1'b0, 1'($urandom), K_CTRL));
    end
    m_sr = din;

    @(negedge i_clk);
    i_start = s; i_stop = p; i_read = r; i_write = w; i_ack_in = ak; i_din = din;
    @(negedge i_clk);
    while (!done) begin
      cyc++;
      if (cyc > 3000) begin
        check("timeout", 32'd0, 32'd1);
        done = 1'b1;
      end else if (o_cmd_ack) begin
        check("done_after_steps", 32'(bi), 32'(q.size()));
        drop_host();
        @(negedge i_clk);
        check("cmd_ack_one_cycle", 32'(o_cmd_ack), 32'd0);
        check("idle_nop", 32'(o_core_cmd), 32'(CMD_NOP));
        check("dout", 32'(o_dout), 32'(m_sr));
        check("ack_out", 32'(o_ack_out), 32'(m_ack_out));
        done = 1'b1;
      end else if (o_core_cmd == CMD_NOP) begin
        check("unexpected_nop_at_step", 32'(bi), 32'(q.size() + 100));
        drop_host();
        done = 1'b1;
      end else if (bi >= q.size()) begin
        check("extra_cmd", 32'(o_core_cmd), 32'(CMD_NOP));
        drop_host();
        done = 1'b1;
      end else begin
        check("cmd", 32'(o_core_cmd), 32'(q[bi].cmd));
        if (q[bi].care) check("txd", 32'(o_core_txd), 32'(q[bi].txd));
        c = o_core_cmd;
        t = o_core_txd;
        if (abort_kind == 1 && bi == abort_idx) begin
          i_core_al = 1'b1;
          @(negedge i_clk);
          i_core_al = 1'b0;
          drop_host();
          check("al_nop", 32'(o_core_cmd), 32'(CMD_NOP));
          check("al_txd", 32'(o_core_txd), 32'd0);
          check("al_no_cmdack", 32'(o_cmd_ack), 32'd0);
          check("al_flag", 32'(o_i2c_al), 32'd1);
          @(negedge i_clk);
          check("al_flag_clear", 32'(o_i2c_al), 32'd0);
          check("al_still_no_cmdack", 32'(o_cmd_ack), 32'd0);
          check("al_idle", 32'(o_core_cmd), 32'(CMD_NOP));
          check("al_dout_kept", 32'(o_dout), 32'(m_sr));
          check("al_ackout_kept", 32'(o_ack_out), 32'(m_ack_out));
          done = 1'b1;
        end else if (abort_kind == 2 && bi == abort_idx) begin
          #2;
          i_rst = 1'b1;
          #1;
          check_reset_values("async_rst");
          drop_host();
          m_ack_out = 1'b0;
          @(negedge i_clk);
          @(negedge i_clk);
          i_rst = 1'b0;
          check_reset_values("rst_held");
          done = 1'b1;
        end else begin
          d = int'($urandom_range(maxdly, 0));
          for (int k = 0; k < d; k++) begin
            @(negedge i_clk);
            check("hold_cmd", 32'(o_core_cmd), 32'(c));
            check("hold_txd", 32'(o_core_txd), 32'(t));
            check("hold_no_cmdack", 32'(o_cmd_ack), 32'd0);
          end
          i_core_rxd = q[bi].rx;
          i_core_ack = 1'b1;
          if (q[bi].kind == K_DATA) m_sr = {m_sr[6:0], q[bi].rx};
          if (q[bi].kind == K_ACK)  m_ack_out = q[bi].rx;
          @(negedge i_clk);
          i_core_ack = 1'b0;
          bi++;
        end
      end
    end
  endtask

  initial begin
    logic s, p, r, w;
    i_rst = 1'b1;
    drop_host();
    i_din = 8'h00; i_core_ack = 1'b0; i_core_rxd = 1'b0; i_core_al = 1'b0;
    m_ack_out = 1'b0;
    m_sr = 8'h00;
    repeat (3) @(negedge i_clk);
    check_reset_values("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // core_ack while idle is ignored
    i_core_ack = 1'b1;
    @(negedge i_clk);
    i_core_ack = 1'b0;
    @(negedge i_clk);
    check("idle_ack_ignored_cmd", 32'(o_core_cmd), 32'(CMD_NOP));
    check("idle_ack_ignored_done", 32'(o_cmd_ack), 32'd0);

    // T1 start+write A5, slave ACK
    do_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 0, 0);
    // T2 read+stop with NACK, received 3C
    do_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 0, 0, 0);
    // T3 stop only
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 2, 0, 0);
    // T4 start+write A5 with long random bit-controller latency
    do_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 50, 0, 0);
    // T5 arbitration loss on the 4th data bit, then a clean write
    do_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(($urandom)), 8'h00, 1'b1, 3, 1, 4);
    do_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h96, 8'h00, 1'b1, 3, 0, 0);
    // T6 reset between clock edges mid-read, then a fresh start+write
    do_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'hC3, 1'b0, 2, 2, 3);
    do_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3E, 8'h00, 1'b0, 2, 0, 0);

    // Random request mix
    for (int n = 0; n < 30; n++) begin
      s = 1'($urandom); p = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
      if (!(s | p | r | w)) w = 1'b1;
      do_req(s, p, r, w, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(4, 0)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
